// File: rtl/game_pkg.sv
// Shared types and codes for the 2048 board-merge path: move directions,
// merge-unit move/strobe codes and the merge sequencer state encoding.
package game_pkg;

  localparam int BOARD_N     = 4;
  localparam int SWEEP_PASSES = 3;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  localparam logic [3:0] MOV_LEFT  = 4'b0100;
  localparam logic [3:0] MOV_RIGHT = 4'b0011;
  localparam logic [3:0] MOV_UP    = 4'b0101;
  localparam logic [3:0] MOV_DOWN  = 4'b0110;

  localparam logic [3:0] ST_MERGE = 4'b1000;
  localparam logic [3:0] ST_IDLE  = 4'b0000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP   = 2'd1,
    S_SETTLE = 2'd2,
    S_FINISH = 2'd3
  } seq_state_t;

  // Direction to merge-unit move code.
  function automatic logic [3:0] dir_to_mov(input dir_t d);
    logic [3:0] m;
    case (d)
      DIR_LEFT:  m = MOV_LEFT;
      DIR_RIGHT: m = MOV_RIGHT;
      DIR_UP:    m = MOV_UP;
      default:   m = MOV_DOWN;
    endcase
    return m;
  endfunction

  // Right/down sweep from the far edge towards index 1.
  function automatic logic dir_is_desc(input dir_t d);
    return (d == DIR_RIGHT) || (d == DIR_DOWN);
  endfunction

endpackage

// File: rtl/sweep_counter.sv
// Row/column index and pass counter for one move. Index runs 1..N-1
// (ascending) or N-1..1 (descending); idx_1 is always idx-1, so index 0 is
// never a merge source. Wrap is detected by comparing against the sweep end.
module sweep_counter
  import game_pkg::*;
#(
  parameter int N      = 4,
  parameter int PASSES = 3,
  localparam int IDX_W  = $clog2(N),
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             desc_in,
  input  logic             step,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] idx_1,
  output logic             last
);

  localparam logic [IDX_W-1:0]  IDX_FIRST = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              desc_q, desc_d;

  logic [IDX_W-1:0] sweep_start;
  logic [IDX_W-1:0] sweep_end;
  logic             at_end;

  assign sweep_start = desc_q ? IDX_LAST  : IDX_FIRST;
  assign sweep_end   = desc_q ? IDX_FIRST : IDX_LAST;
  assign at_end      = (idx_q == sweep_end);
  assign last        = at_end && (pass_q == PASS_LAST);
  assign idx         = idx_q;
  assign idx_1       = idx_q - IDX_W'(1);

  // Next index/pass: load restarts the sweep, step advances or wraps to a new pass.
  always_comb begin
    idx_d  = idx_q;
    pass_d = pass_q;
    desc_d = desc_q;
    if (load) begin
      desc_d = desc_in;
      idx_d  = desc_in ? IDX_LAST : IDX_FIRST;
      pass_d = '0;
    end else if (step) begin
      if (at_end) begin
        idx_d  = sweep_start;
        pass_d = pass_q + PASS_W'(1);
      end else begin
        idx_d = desc_q ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= IDX_FIRST;
      pass_q <= '0;
      desc_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      pass_q <= pass_d;
      desc_q <= desc_d;
    end
  end

endmodule

// File: rtl/merge_sequencer.sv
// Board-merge initiator: takes one move per handshake and strobes the merge
// unit once per index over several sweeps, alternating a strobe cycle with a
// settle cycle so the registered board can update. Ends on sweep completion
// or when the merge unit reports checked, then pulses done.
//
// Handshake: a move is accepted on the rising edge where mv_valid and
// mv_ready are both high; mv_ready is high only in IDLE, mv_dir is captured
// on that edge, and mv_valid at any other time is ignored rather than queued.
module merge_sequencer
  import game_pkg::*;
#(
  parameter int N      = 4,
  parameter int PASSES = 3,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mv_valid,
  input  logic [1:0]       mv_dir,
  output logic             mv_ready,
  output logic [3:0]       mov,
  output logic [3:0]       estado,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] idx_1,
  input  logic             checked,
  output logic             busy,
  output logic             done,
  output seq_state_t       dbg_state
);

  seq_state_t state_q, state_d;
  logic [3:0] mov_q, mov_d;
  logic       cnt_load;
  logic       cnt_step;
  logic       cnt_last;
  dir_t       dir_in;

  assign dir_in    = dir_t'(mv_dir);
  assign mov       = mov_q;
  assign dbg_state = state_q;

  sweep_counter #(
    .N      (N),
    .PASSES (PASSES)
  ) u_sweep (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .desc_in (dir_is_desc(dir_in)),
    .step    (cnt_step),
    .idx     (idx),
    .idx_1   (idx_1),
    .last    (cnt_last)
  );

  // Next state, counter controls and Moore outputs; checked only matters in SETTLE.
  always_comb begin
    state_d  = state_q;
    mov_d    = mov_q;
    estado   = ST_IDLE;
    done     = 1'b0;
    busy     = 1'b1;
    mv_ready = 1'b0;
    cnt_load = 1'b0;
    cnt_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy     = 1'b0;
        mv_ready = 1'b1;
        if (mv_valid) begin
          state_d  = S_STEP;
          cnt_load = 1'b1;
          mov_d    = dir_to_mov(dir_in);
        end
      end
      S_STEP: begin
        estado  = ST_MERGE;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (checked || cnt_last) begin
          state_d = S_FINISH;
        end else begin
          cnt_step = 1'b1;
          state_d  = S_STEP;
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and held move code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mov_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      mov_q   <= mov_d;
    end
  end

endmodule

// File: tb/tb_merge_sequencer.sv
// Directed bench for merge_sequencer: table of single moves plus hand-written
// reset, back-pressure and back-to-back sequences.
module tb_merge_sequencer;
  import game_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       mv_valid;
  logic [1:0] mv_dir;
  logic       mv_ready;
  logic [3:0] mov;
  logic [3:0] estado;
  logic [1:0] idx;
  logic [1:0] idx_1;
  logic       checked;
  logic       busy;
  logic       done;
  seq_state_t dbg_state;

  int n_cmp;
  int n_fail;
  logic [1:0] exp_q[$];

  merge_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mv_valid  (mv_valid),
    .mv_dir    (mv_dir),
    .mv_ready  (mv_ready),
    .mov       (mov),
    .estado    (estado),
    .idx       (idx),
    .idx_1     (idx_1),
    .checked   (checked),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] dir;
    int         chk_c;
    logic [3:0] exp_mov;
    bit         asc;
    int         exp_done;
    int         exp_strobes;
  } vec_t;

  vec_t vecs[8];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. Cycle c is the interval after the
  // (c-1)th rising edge following acceptance (accept edge = cycle 0).
  task automatic run_seq(input logic [1:0] dir, input int chk_c, input logic [3:0] exp_mov,
                         input bit asc, input int exp_done, input int exp_strobes,
                         input bit hold, input logic [1:0] hold_dir, input string tag);
    int strobes, done_at, done_cnt, bad_idx, bad_idx1, bad_mov, bad_busy, bad_ready;
    logic [1:0] e;
    strobes = 0; done_at = 0; done_cnt = 0; bad_idx = 0; bad_idx1 = 0;
    bad_mov = 0; bad_busy = 0; bad_ready = 0;
    exp_q.delete();
    for (int n = 0; n < exp_strobes; n++) begin
      e = asc ? 2'((n % 3) + 1) : 2'(3 - (n % 3));
      exp_q.push_back(e);
    end
    cmp({tag, " ready_before"}, 32'(mv_ready), 32'd1);
    mv_valid = 1'b1;
    mv_dir   = dir;
    @(posedge clk);
    #1;
    if (hold) mv_dir = hold_dir;
    else mv_valid = 1'b0;
    for (int c = 1; c <= exp_done + 1; c++) begin
      @(negedge clk);
      if (estado === ST_MERGE) begin
        strobes++;
        if (exp_q.size() == 0) bad_idx++;
        else begin
          e = exp_q.pop_front();
          if (idx !== e) bad_idx++;
        end
        if (idx_1 !== (idx - 2'd1)) bad_idx1++;
      end else if (estado !== ST_IDLE) begin
        bad_idx++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = c;
      end
      if (mov !== exp_mov) bad_mov++;
      if (busy !== (c <= exp_done)) bad_busy++;
      if (mv_ready !== (c > exp_done)) bad_ready++;
      checked = (c == chk_c);
    end
    checked = 1'b0;
    cmp({tag, " done_cycle"}, 32'(done_at), 32'(exp_done));
    cmp({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
    cmp({tag, " strobes"}, 32'(strobes), 32'(exp_strobes));
    cmp({tag, " idx_left"}, 32'(exp_q.size()), 32'd0);
    cmp({tag, " idx_bad"}, 32'(bad_idx), 32'd0);
    cmp({tag, " idx_1_bad"}, 32'(bad_idx1), 32'd0);
    cmp({tag, " mov_bad"}, 32'(bad_mov), 32'd0);
    cmp({tag, " busy_bad"}, 32'(bad_busy), 32'd0);
    cmp({tag, " ready_bad"}, 32'(bad_ready), 32'd0);
  endtask

  initial begin
    int strobes;
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; mv_valid = 1'b0; mv_dir = 2'd0; checked = 1'b0;

    // dir, chk_c, mov, ascending, done cycle, strobe count
    vecs[0] = '{2'd0, 0,  MOV_LEFT,  1'b1, 19, 9};
    vecs[1] = '{2'd3, 0,  MOV_DOWN,  1'b0, 19, 9};
    vecs[2] = '{2'd1, 6,  MOV_RIGHT, 1'b0, 7,  3};
    vecs[3] = '{2'd2, 0,  MOV_UP,    1'b1, 19, 9};
    vecs[4] = '{2'd0, 2,  MOV_LEFT,  1'b1, 3,  1};
    vecs[5] = '{2'd2, 10, MOV_UP,    1'b1, 11, 5};
    vecs[6] = '{2'd3, 5,  MOV_DOWN,  1'b0, 19, 9};
    vecs[7] = '{2'd1, 18, MOV_RIGHT, 1'b0, 19, 9};

    // Reset values
    repeat (2) @(negedge clk);
    cmp("rst mov", 32'(mov), 32'h0);
    cmp("rst estado", 32'(estado), 32'(ST_IDLE));
    cmp("rst idx", 32'(idx), 32'd1);
    cmp("rst idx_1", 32'(idx_1), 32'd0);
    cmp("rst busy", 32'(busy), 32'd0);
    cmp("rst done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    cmp("rst ready", 32'(mv_ready), 32'd1);

    // Table of single moves; checked held high in IDLE beforehand must be ignored
    foreach (vecs[i]) begin
      checked = 1'b1;
      repeat (2) @(negedge clk);
      cmp($sformatf("v%0d idle_state", i), 32'(dbg_state), 32'(S_IDLE));
      cmp($sformatf("v%0d idle_estado", i), 32'(estado), 32'(ST_IDLE));
      run_seq(vecs[i].dir, vecs[i].chk_c, vecs[i].exp_mov, vecs[i].asc,
              vecs[i].exp_done, vecs[i].exp_strobes, 1'b0, 2'd0, $sformatf("v%0d", i));
    end

    // Back-pressure: valid held with a new dir while busy; second move uses it
    @(negedge clk);
    run_seq(2'd0, 0, MOV_LEFT, 1'b1, 19, 9, 1'b1, 2'd3, "bp first");
    run_seq(2'd3, 0, MOV_DOWN, 1'b0, 19, 9, 1'b0, 2'd0, "bp second");

    // Back-to-back up moves with valid held: done at 19 and 39
    @(negedge clk);
    run_seq(2'd2, 0, MOV_UP, 1'b1, 19, 9, 1'b1, 2'd2, "b2b first");
    run_seq(2'd2, 0, MOV_UP, 1'b1, 19, 9, 1'b0, 2'd0, "b2b second");

    // Reset asserted mid-STEP aborts at once
    @(negedge clk);
    mv_valid = 1'b1;
    mv_dir   = 2'd0;
    @(posedge clk);
    #1 mv_valid = 1'b0;
    repeat (3) @(negedge clk);
    cmp("midrst pre_estado", 32'(estado), 32'(ST_MERGE));
    rst_n = 1'b0;
    #1;
    cmp("midrst estado", 32'(estado), 32'(ST_IDLE));
    cmp("midrst busy", 32'(busy), 32'd0);
    cmp("midrst done", 32'(done), 32'd0);
    cmp("midrst idx", 32'(idx), 32'd1);
    strobes = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (estado === ST_MERGE) strobes++;
    end
    cmp("midrst strobes", 32'(strobes), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    cmp("midrst ready", 32'(mv_ready), 32'd1);
    cmp("midrst state", 32'(dbg_state), 32'(S_IDLE));
    repeat (4) @(negedge clk);
    cmp("midrst no_restart", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
